// File: rtl/pd_axis_sched_if.sv
// rtl/pd_axis_sched_if.sv - sample/command inputs and PD term outputs of pd_axis_sched
interface pd_axis_sched_if;
  logic               vld;
  logic signed [15:0] ptch;
  logic signed [15:0] roll;
  logic signed [15:0] yaw;
  logic signed [15:0] d_ptch;
  logic signed [15:0] d_roll;
  logic signed [15:0] d_yaw;
  logic signed [9:0]  ptch_pterm;
  logic signed [11:0] ptch_dterm;
  logic signed [9:0]  roll_pterm;
  logic signed [11:0] roll_dterm;
  logic signed [9:0]  yaw_pterm;
  logic signed [11:0] yaw_dterm;
  logic               busy;
  logic               pd_rdy;
  logic               ovr;

  modport master (
    output vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    input  ptch_pterm, ptch_dterm, roll_pterm, roll_dterm, yaw_pterm, yaw_dterm,
    input  busy, pd_rdy, ovr
  );

  modport slave (
    input  vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    output ptch_pterm, ptch_dterm, roll_pterm, roll_dterm, yaw_pterm, yaw_dterm,
    output busy, pd_rdy, ovr
  );
endinterface

// File: rtl/pd_axis_sched.sv
// rtl/pd_axis_sched.sv - time-multiplexed PD controller for pitch, roll and yaw
module pd_axis_sched #(
  parameter int                D_QUEUE_DEPTH = 12,
  parameter logic signed [4:0] DTERM         = 5'sd7
) (
  input logic              clk,
  input logic              rst_n,
  pd_axis_sched_if.slave   bus
);
  localparam int PW = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] WPTR_LAST = PW'(D_QUEUE_DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         axis;
  logic [PW-1:0]      wptr;
  logic               ovr_q;
  logic signed [15:0] act_q [3];
  logic signed [15:0] des_q [3];
  logic signed [9:0]  pterm_q [3];
  logic signed [11:0] dterm_q [3];
  logic signed [9:0]  hist [3][D_QUEUE_DEPTH];

  logic signed [16:0] err;
  logic signed [9:0]  err_sat;
  logic signed [9:0]  pterm_c;
  logic signed [9:0]  hist_rd;
  logic signed [10:0] d_diff;
  logic signed [6:0]  d_sat;
  logic signed [11:0] dterm_c;

  // Shared datapath, steered by the axis currently in CALC.
  always_comb begin
    err     = 17'(act_q[axis]) - 17'(des_q[axis]);
    err_sat = err[9:0];
    if (err > 17'sd511)
      err_sat = 10'sd511;
    else if (err < -17'sd512)
      err_sat = -10'sd512;
    pterm_c = (err_sat >>> 1) + (err_sat >>> 3);
    hist_rd = hist[axis][wptr];
    d_diff  = 11'(err_sat) - 11'(hist_rd);
    d_sat   = d_diff[6:0];
    if (d_diff > 11'sd63)
      d_sat = 7'sd63;
    else if (d_diff < -11'sd64)
      d_sat = -7'sd64;
    dterm_c = 12'(DTERM) * 12'(d_sat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      axis  <= 2'd0;
      wptr  <= '0;
      ovr_q <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        act_q[a]   <= '0;
        des_q[a]   <= '0;
        pterm_q[a] <= '0;
        dterm_q[a] <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++)
          hist[a][i] <= '0;
      end
    end else begin
      ovr_q <= bus.vld && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.vld) begin
            act_q[0] <= bus.ptch;
            act_q[1] <= bus.roll;
            act_q[2] <= bus.yaw;
            des_q[0] <= bus.d_ptch;
            des_q[1] <= bus.d_roll;
            des_q[2] <= bus.d_yaw;
            axis     <= 2'd0;
            state    <= CALC;
          end
        end
        CALC: begin
          pterm_q[axis]    <= pterm_c;
          dterm_q[axis]    <= dterm_c;
          hist[axis][wptr] <= err_sat;
          if (axis == 2'd2)
            state <= DONE;
          else
            axis <= axis + 2'd1;
        end
        DONE: begin
          wptr  <= (wptr == WPTR_LAST) ? '0 : wptr + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ptch_pterm = pterm_q[0];
  assign bus.ptch_dterm = dterm_q[0];
  assign bus.roll_pterm = pterm_q[1];
  assign bus.roll_dterm = dterm_q[1];
  assign bus.yaw_pterm  = pterm_q[2];
  assign bus.yaw_dterm  = dterm_q[2];
  assign bus.busy       = (state != IDLE);
  assign bus.pd_rdy     = (state == DONE);
  assign bus.ovr        = ovr_q;
endmodule

// File: tb/tb_pd_axis_sched.sv
// tb/tb_pd_axis_sched.sv - scoreboard bench for pd_axis_sched with a queue-based reference model
module tb_pd_axis_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  pd_axis_sched_if bus();

  pd_axis_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p[3];
    int d[3];
    int rdy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   hq0[$];
  int   hq1[$];
  int   hq2[$];
  int   next_free = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    hq0 = {}; hq1 = {}; hq2 = {};
    for (int i = 0; i < 12; i++) begin
      hq0.push_back(0); hq1.push_back(0); hq2.push_back(0);
    end
    exp_q = {};
    ovr_q = {};
    next_free = 0;
  endtask

  // Oldest error leaves the queue, newest joins it: one step per accepted sample.
  task automatic model_axis(input int a, input int act, input int des, output int p, output int d);
    int es, old;
    es = sat(act - des, -512, 511);
    p  = (es >>> 1) + (es >>> 3);
    case (a)
      0: begin old = hq0.pop_front(); hq0.push_back(es); end
      1: begin old = hq1.pop_front(); hq1.push_back(es); end
      default: begin old = hq2.pop_front(); hq2.push_back(es); end
    endcase
    d = 7 * sat(es - old, -64, 63);
  endtask

  task automatic send(input int a0, input int a1, input int a2, input int d0, input int d1, input int d2);
    int   edge_n;
    exp_t e;
    @(posedge clk); #1;
    bus.ptch = 16'(a0); bus.roll = 16'(a1); bus.yaw = 16'(a2);
    bus.d_ptch = 16'(d0); bus.d_roll = 16'(d1); bus.d_yaw = 16'(d2);
    bus.vld = 1'b1;
    edge_n = cyc + 1;
    if (edge_n >= next_free) begin
      model_axis(0, int'(bus.ptch), int'(bus.d_ptch), e.p[0], e.d[0]);
      model_axis(1, int'(bus.roll), int'(bus.d_roll), e.p[1], e.d[1]);
      model_axis(2, int'(bus.yaw),  int'(bus.d_yaw),  e.p[2], e.d[2]);
      e.rdy_cyc = edge_n + 3;
      exp_q.push_back(e);
      next_free = edge_n + 5;
    end else begin
      ovr_q.push_back(edge_n);
    end
    @(posedge clk); #1;
    bus.vld = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.pd_rdy;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_ptch_p"}, int'(bus.ptch_pterm), 0);
    chk({name, "_ptch_d"}, int'(bus.ptch_dterm), 0);
    chk({name, "_roll_p"}, int'(bus.roll_pterm), 0);
    chk({name, "_roll_d"}, int'(bus.roll_dterm), 0);
    chk({name, "_yaw_p"},  int'(bus.yaw_pterm), 0);
    chk({name, "_yaw_d"},  int'(bus.yaw_dterm), 0);
    chk({name, "_busy"},   int'(bus.busy), 0);
    chk({name, "_pd_rdy"}, int'(bus.pd_rdy), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_idle_zero("rst_pulse");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every pd_rdy and ovr pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.pd_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pd_rdy", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdy_latency", cyc, e.rdy_cyc);
        chk("ptch_pterm", int'(bus.ptch_pterm), e.p[0]);
        chk("ptch_dterm", int'(bus.ptch_dterm), e.d[0]);
        chk("roll_pterm", int'(bus.roll_pterm), e.p[1]);
        chk("roll_dterm", int'(bus.roll_dterm), e.d[1]);
        chk("yaw_pterm",  int'(bus.yaw_pterm),  e.p[2]);
        chk("yaw_dterm",  int'(bus.yaw_dterm),  e.d[2]);
      end
    end
    if (rst_n && bus.ovr) begin
      if (ovr_q.size() == 0) chk("unexpected_ovr", 1, 0);
      else chk("ovr_cycle", cyc, ovr_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vld = 0;
    bus.ptch = 0; bus.roll = 0; bus.yaw = 0;
    bus.d_ptch = 0; bus.d_roll = 0; bus.d_yaw = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_ovr", int'(bus.ovr), 0);
    rst_n = 1'b1;

    send(0, 0, 0, 0, 0, 0);
    wait_rdy("zero");

    send(16'h0100, 0, 0, 0, 0, 0);
    wait_rdy("pitch256");
    chk("dir_ptch_p", int'(bus.ptch_pterm), 160);
    chk("dir_ptch_d", int'(bus.ptch_dterm), 441);
    chk("dir_roll_p0", int'(bus.roll_pterm), 0);

    send(0, 16'h7FFF, 16'h8000, 0, 16'h8000, 16'h7FFF);
    wait_rdy("sat");
    chk("sat_roll_p", int'(bus.roll_pterm), 318);
    chk("sat_roll_d", int'(bus.roll_dterm), 441);
    chk("sat_yaw_p",  int'(bus.yaw_pterm), -320);
    chk("sat_yaw_d",  int'(bus.yaw_dterm), -448);

    // Depth: 13 accepted samples of error 256, with a dropped vld after the fifth.
    pulse_reset();
    for (int k = 1; k <= 13; k++) begin
      send(256, 0, 0, 0, 0, 0);
      if (k == 5) send(0, 300, 0, 0, 0, 0);
      wait_rdy("depth");
      chk($sformatf("depth_d_%0d", k), int'(bus.ptch_dterm), (k <= 12) ? 441 : 0);
    end

    pulse_reset();
    for (int k = 1; k <= 13; k++) begin
      send((k <= 12) ? 256 : 0, 0, 0, 0, 0, 0);
      wait_rdy("depth2");
      if (k == 13) chk("depth2_d_13", int'(bus.ptch_dterm), -448);
    end

    // Reset during roll's CALC cycle.
    send(256, 100, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_idle_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send(256, 0, 0, 0, 0, 0);
    wait_rdy("after_midrst");
    chk("after_midrst_d", int'(bus.ptch_dterm), 441);

    for (int n = 0; n < 80; n++) begin
      int v[6];
      for (int j = 0; j < 6; j++)
        v[j] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1200)) - 600
                                          : int'(16'($urandom)) - 32768;
      send(v[0], v[1], v[2], v[3], v[4], v[5]);
      repeat ($urandom_range(0, 7)) @(posedge clk);
    end

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ovr_q_drained", ovr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
